// File: rtl/test_monitor.sv
// test_monitor: aggregates N self-checking sub-test channels into one registered
// pass/fail/done verdict with a cycle-count timeout watchdog.
module test_monitor #(
    parameter int NUM_TESTS      = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16,
    parameter int IDX_WIDTH      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] test_result,
    input  logic [NUM_TESTS-1:0] test_done,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] done_mask,
    output logic [IDX_WIDTH-1:0] first_fail_idx,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state;
    logic [NUM_TESTS-1:0] next_done, next_fail;
    logic [CNT_WIDTH-1:0] next_count;
    logic [IDX_WIDTH-1:0] low_idx;
    logic all_done, hit_limit;
    always_comb begin
        next_done  = done_mask | test_done;
        next_fail  = fail_mask | test_result;
        next_count = cycle_count + 1'b1;
        all_done   = &next_done;
        hit_limit  = next_count == CNT_WIDTH'(TIMEOUT_CYCLES);
        low_idx    = '0;
        // Scan downward so the lowest failing channel is the one left standing
        for (int i = NUM_TESTS - 1; i >= 0; i--)
            if (test_result[i]) low_idx = IDX_WIDTH'(i);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            fail_mask      <= '0;
            done_mask      <= '0;
            first_fail_idx <= '0;
            cycle_count    <= '0;
        end else begin
            case (state)
                IDLE, FINISH: if (start) begin
                    state          <= RUN;
                    busy           <= 1'b1;
                    done           <= 1'b0;
                    pass           <= 1'b0;
                    fail           <= 1'b0;
                    timeout        <= 1'b0;
                    fail_mask      <= '0;
                    done_mask      <= '0;
                    first_fail_idx <= '0;
                    cycle_count    <= '0;
                end
                RUN: begin
                    done_mask   <= next_done;
                    fail_mask   <= next_fail;
                    cycle_count <= next_count;
                    if (fail_mask == '0 && test_result != '0) first_fail_idx <= low_idx;
                    // Completion takes priority over a watchdog expiring on the same edge
                    if (all_done || hit_limit) begin
                        state   <= FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= ~all_done;
                        pass    <= all_done && next_fail == '0;
                        fail    <= ~(all_done && next_fail == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: scoreboard bench for test_monitor with three channels and a 16-cycle watchdog.
module tb_test_monitor;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0]  test_result = '0, test_done = '0;
    logic        busy, done, pass, fail, timeout;
    logic [2:0]  fail_mask, done_mask;
    logic [1:0]  first_fail_idx;
    logic [15:0] cycle_count;

    test_monitor #(.NUM_TESTS(3), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16), .IDX_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .start(start), .test_result(test_result), .test_done(test_done),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_mask(fail_mask), .done_mask(done_mask), .first_fail_idx(first_fail_idx),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dm, fm;
        logic [1:0]  idx;
        logic [15:0] cnt;
        logic        to, ps;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] stim_done(input int n, input int d0, input int d1, input int d2);
        return {n == d2, n == d1, n == d0};
    endfunction

    function automatic logic [2:0] stim_res(input int n, input int c1, input logic [2:0] v1,
                                            input int c2, input logic [2:0] v2);
        return (n == c1 ? v1 : 3'b000) | (n == c2 ? v2 : 3'b000);
    endfunction

    // d*: RUN cycle at which each channel pulses done (0 = never); c*/v*: failure events;
    // sc: RUN cycle at which a stray start is pulsed (0 = none)
    task automatic run(input string nm, input int d0, input int d1, input int d2,
                       input int c1, input logic [2:0] v1, input int c2, input logic [2:0] v2,
                       input int sc);
        exp_t e;
        logic [2:0] rv;
        bit fin;
        e = '{dm: 3'b000, fm: 3'b000, idx: 2'd0, cnt: 16'd0, to: 1'b0, ps: 1'b0};
        for (int n = 1; n <= 16; n++) begin
            rv = stim_res(n, c1, v1, c2, v2);
            if (e.fm == 3'b000 && rv != 3'b000)
                for (int i = 2; i >= 0; i--) if (rv[i]) e.idx = 2'(i);
            e.dm |= stim_done(n, d0, d1, d2);
            e.fm |= rv;
            e.cnt = 16'(n);
            if (e.dm == 3'b111) break;
            if (n == 16) e.to = 1'b1;
        end
        e.ps = e.fm == 3'b000 && !e.to;
        sb.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({nm, "_busy1"}, busy, 1);
        check({nm, "_clr_cnt"}, cycle_count, 0);
        check({nm, "_clr_masks"}, {timeout, fail_mask, done_mask, first_fail_idx}, 0);
        check({nm, "_done_pass_low"}, {done, pass}, 0);
        fin = 1'b0;
        for (int n = 1; n <= 40 && !fin; n++) begin
            test_done   = stim_done(n, d0, d1, d2);
            test_result = stim_res(n, c1, v1, c2, v2);
            start       = n == sc;
            @(negedge clk);
            test_done   = '0;
            test_result = '0;
            start       = 1'b0;
            fin         = done;
        end
        e = sb.pop_front();
        if (!fin) check({nm, "_finish_wait"}, 0, 1);
        else begin
            check({nm, "_done_mask"}, done_mask, e.dm);
            check({nm, "_fail_mask"}, fail_mask, e.fm);
            check({nm, "_cycle_count"}, cycle_count, e.cnt);
            check({nm, "_timeout"}, timeout, e.to);
            check({nm, "_pass_fail"}, {pass, fail}, {e.ps, ~e.ps});
            check({nm, "_busy0"}, busy, 0);
            if (e.fm != 3'b000) check({nm, "_first_idx"}, first_fail_idx, e.idx);
            test_done   = 3'b111;
            test_result = 3'b111;
            @(negedge clk);
            test_done   = '0;
            test_result = '0;
            check({nm, "_hold"}, {done, fail_mask, done_mask, cycle_count}, {1'b1, e.fm, e.dm, e.cnt});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_flags", {busy, done, pass, fail, timeout}, 0);
        check("rst_vals", {fail_mask, done_mask, first_fail_idx, cycle_count}, 0);
        reset = 1'b0;
        run("clean",   2, 5, 7,  0, 3'b000, 0, 3'b000, 0);
        run("fail2",   2, 5, 7,  3, 3'b100, 0, 3'b000, 0);
        run("multi",   2, 5, 7,  1, 3'b011, 4, 3'b100, 0);
        run("tmo",     2, 0, 7,  0, 3'b000, 0, 3'b000, 0);
        run("edge16",  2, 5, 16, 0, 3'b000, 0, 3'b000, 0);
        run("stray",   2, 5, 7,  6, 3'b010, 0, 3'b000, 3);
        run("termfl",  1, 3, 4,  4, 3'b001, 0, 3'b000, 0);
        // Reset mid-clock during RUN cycle 4 must clear everything without an edge
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            test_done   = n == 2 ? 3'b001 : 3'b000;
            test_result = n == 2 ? 3'b010 : 3'b000;
            @(negedge clk);
        end
        test_done   = '0;
        test_result = '0;
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_flags", {busy, done, pass, fail, timeout}, 0);
        check("async_rst_vals", {fail_mask, done_mask, first_fail_idx, cycle_count}, 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, done}, 0);
        run("after_rst", 4, 2, 3, 0, 3'b000, 0, 3'b000, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
- Parametrised, synthesisable aggregator for N self-checking sub-tests. Each sub-test drives a result (failure) line and a done line.
- Latches per-channel completion and failure, and records the first failing channel.
- Enforces a cycle-count timeout watchdog.
- Presents one pass/fail/done verdict to the top-level bench or an on-board LED/UART reporter.

Parameters:
- NUM_TESTS, 3, number of sub-test channels (1..16).
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before a timeout is declared (>=1).
- CNT_WIDTH, 16, width of cycle_count; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.
- IDX_WIDTH, 2, width of first_fail_idx; must satisfy 2^IDX_WIDTH >= NUM_TESTS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or FINISH.
- test_result  in  NUM_TESTS  per-channel failure flag; high on any RUN cycle = that channel failed.
- test_done  in  NUM_TESTS  per-channel completion; may pulse or hold.
- busy  out  1  high while in RUN.
- done  out  1  high while in FINISH.
- pass  out  1  high in FINISH when fail_mask==0 and timeout==0.
- fail  out  1  high in FINISH when any failure or timeout.
- timeout  out  1  sticky; run ended by watchdog.
- fail_mask  out  NUM_TESTS  sticky OR of test_result over the run.
- done_mask  out  NUM_TESTS  sticky OR of test_done over the run.
- first_fail_idx  out  IDX_WIDTH  index of first channel to fail; valid when fail_mask!=0.
- cycle_count  out  CNT_WIDTH  number of RUN cycles elapsed.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy, done, pass, fail, timeout, fail_mask, done_mask, first_fail_idx and cycle_count are all 0.
- States: IDLE, RUN, FINISH. All outputs are registered; none depend combinationally on inputs.
- IDLE, start=1 at an edge:
  - state=RUN next cycle.
  - Clears masks, timeout, first_fail_idx and cycle_count.
- RUN, each rising edge, computed as a single update:
  - next_done = done_mask | test_done.
  - next_fail = fail_mask | test_result.
  - next_count = cycle_count + 1.
  - If fail_mask==0 and test_result!=0: first_fail_idx = lowest set bit index of test_result.
  - If next_done is all ones: state=FINISH and timeout stays 0.
  - Else if next_count==TIMEOUT_CYCLES: state=FINISH and timeout=1.
  - Otherwise remain in RUN.
  - Masks and cycle_count load their next_* values on every RUN edge, including the terminating edge.
- start in RUN is ignored.
- FINISH:
  - Holds all results; test_result and test_done are ignored.
  - pass = (fail_mask==0) & ~timeout; fail = ~pass; done=1.
  - start=1 at an edge re-enters RUN with the same clears as from IDLE, so done and pass drop next cycle.
- Latency: start edge k gives busy=1 from cycle k+1. The edge that sees the final done gives done=1 in the following cycle.
- Simultaneous events:
  - Final done and timeout on the same edge: done wins, timeout=0.
  - Failure on the terminating edge is captured in fail_mask.
  - Several channels fail on the same first-failure edge: the lowest index is recorded.
- Channels whose test_done pulses before other channels finish stay latched in done_mask.
- cycle_count never exceeds TIMEOUT_CYCLES and holds its final value in FINISH.
- reset mid-run aborts immediately to IDLE, with all outputs cleared asynchronously.

Test Plan:
- NUM_TESTS=3, TIMEOUT_CYCLES=16. Pulse start. test_done bits 0, 1 and 2 pulse (1 cycle each) at RUN cycles 2, 5 and 7. test_result=0. -> After cycle 7: done=1, pass=1, fail=0, done_mask=3'b111, cycle_count=7, busy=0.
- As above, plus test_result[2] high for one cycle at RUN cycle 3. -> Run still ends at cycle 7; fail=1, pass=0, fail_mask=3'b100, first_fail_idx=2.
- test_result=3'b011 at RUN cycle 1, then test_result[2] at cycle 4. -> first_fail_idx=0, fail_mask=3'b111.
- test_done[1] never asserted. -> FINISH after RUN cycle 16; timeout=1, fail=1, cycle_count=16, done_mask=3'b101.
- Last test_done arrives exactly at RUN cycle 16. -> timeout=0, pass=1, cycle_count=16.
- start pulsed during RUN -> no effect. reset asserted mid-clock at RUN cycle 4 -> all outputs 0 without waiting for an edge, state IDLE. Restart from FINISH -> masks and cycle_count read 0 in the first RUN cycle.
